// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/sequencing controller for the 5-stage RV64I pipeline.
// Optional perf counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int DRAIN_CYCLES      = 3,
  parameter int PERF_W            = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_exception,
  input  logic              id_invalid,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rd,
  input  logic              ex_redirect,
  input  logic              mem_busy,
  input  logic              resume,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_stall,
  output logic              exmem_stall,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              memwb_flush,
  output logic              halted,
  output logic [1:0]        exc_cause,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    DRAIN    = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam bit         MULTI_LD = (LOAD_STALL_CYCLES > 1);
  localparam logic [3:0] LD_INIT  = MULTI_LD ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;
  localparam logic [3:0] DR_INIT  = 4'(DRAIN_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] pend_cause, pend_nxt, cause_nxt, trap_cause;
  logic       halted_nxt, load_use, trap;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  assign trap       = id_valid && (id_exception || id_invalid);
  assign trap_cause = id_exception ? 2'b01 : 2'b10;

  // State register; the trap cause becomes visible only once HALT is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      cnt        <= 4'd0;
      pend_cause <= 2'b00;
      exc_cause  <= 2'b00;
      halted     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pend_cause <= pend_nxt;
      exc_cause  <= cause_nxt;
      halted     <= halted_nxt;
    end
  end

  // Next-state logic: mem_busy freezes everything, redirect cancels any sequence
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pend_nxt   = pend_cause;
    cause_nxt  = exc_cause;
    halted_nxt = halted;
    if (state == HALT) begin
      if (resume) begin
        state_nxt  = RUN;
        halted_nxt = 1'b0;
      end else begin
        state_nxt = HALT;
      end
    end else if (mem_busy) begin
      state_nxt = state;
    end else if (ex_redirect) begin
      state_nxt = RUN;
      pend_nxt  = 2'b00;
    end else if (state == RUN) begin
      if (load_use) begin
        if (MULTI_LD) begin
          state_nxt = LD_STALL;
          cnt_nxt   = LD_INIT;
        end else begin
          state_nxt = RUN;
        end
      end else if (trap) begin
        state_nxt = DRAIN;
        cnt_nxt   = DR_INIT;
        pend_nxt  = trap_cause;
      end else begin
        state_nxt = RUN;
      end
    end else if (cnt != 4'd0) begin
      cnt_nxt = cnt - 4'd1;
    end else if (state == DRAIN) begin
      state_nxt  = HALT;
      halted_nxt = 1'b1;
      cause_nxt  = pend_cause;
    end else begin
      state_nxt = RUN;
    end
  end

  // Stall/flush outputs; a resume cycle only discards the trapped instruction in IF/ID
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    if (!rst_n) begin
      pc_stall = 1'b0;
    end else if (state == HALT) begin
      if (resume) begin
        ifid_flush = 1'b1;
      end else begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
      end
    end else if (mem_busy) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_flush = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if ((state != RUN) || load_use || trap) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end else begin
      pc_stall = 1'b0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};
  logic stall_take, redirect_take;
  assign stall_take    = pc_stall && (state != HALT);
  assign redirect_take = (state != HALT) && !mem_busy && ex_redirect;

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= {PERF_W{1'b0}};
      flush_count  <= {PERF_W{1'b0}};
    end else begin
      if (stall_take && (stall_cycles != {PERF_W{1'b1}})) stall_cycles <= stall_cycles + PERF_ONE;
      if (redirect_take && (flush_count != {PERF_W{1'b1}})) flush_count <= flush_count + PERF_ONE;
    end
  end
`else
  assign stall_cycles = {PERF_W{1'b0}};
  assign flush_count  = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus a randomized run
// checked against a debt-counting reference model.
module tb_pipeline_ctrl;
  localparam int DRAIN = 3;
  localparam int LDN   = 1;
  localparam logic [6:0] NONE_V   = 7'b0000000;
  localparam logic [6:0] LU_V     = 7'b1100010;
  localparam logic [6:0] BUSY_V   = 7'b1111001;
  localparam logic [6:0] REDIR_V  = 7'b0000110;
  localparam logic [6:0] HALT_V   = 7'b1111000;
  localparam logic [6:0] RESUME_V = 7'b0000100;

  logic clk = 1'b0;
  logic rst_n, id_valid, id_use_rs1, id_use_rs2, id_exception, id_invalid;
  logic ex_mem_read, ex_redirect, mem_busy, resume;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic a_pc, a_ifid, a_idex, a_exmem, a_ifid_f, a_idex_f, a_memwb_f, a_halted;
  logic b_pc, b_ifid, b_idex, b_exmem, b_ifid_f, b_idex_f, b_memwb_f, b_halted;
  logic [1:0] a_cause, b_cause;
  logic [31:0] a_stalls, a_flushes, b_stalls, b_flushes;
  wire [6:0] vec  = {a_pc, a_ifid, a_idex, a_exmem, a_ifid_f, a_idex_f, a_memwb_f};
  wire [6:0] vec3 = {b_pc, b_ifid, b_idex, b_exmem, b_ifid_f, b_idex_f, b_memwb_f};
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_exception(id_exception),
    .id_invalid(id_invalid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy), .resume(resume),
    .pc_stall(a_pc), .ifid_stall(a_ifid), .idex_stall(a_idex), .exmem_stall(a_exmem),
    .ifid_flush(a_ifid_f), .idex_flush(a_idex_f), .memwb_flush(a_memwb_f),
    .halted(a_halted), .exc_cause(a_cause), .stall_cycles(a_stalls), .flush_count(a_flushes));

  pipeline_ctrl #(.LOAD_STALL_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_exception(id_exception),
    .id_invalid(id_invalid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy), .resume(resume),
    .pc_stall(b_pc), .ifid_stall(b_ifid), .idex_stall(b_idex), .exmem_stall(b_exmem),
    .ifid_flush(b_ifid_f), .idex_flush(b_idex_f), .memwb_flush(b_memwb_f),
    .halted(b_halted), .exc_cause(b_cause), .stall_cycles(b_stalls), .flush_count(b_flushes));

  task automatic idle();
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_exception = 1'b0; id_invalid = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    ex_redirect = 1'b0; mem_busy = 1'b0; resume = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    mem_busy = 1'b1;
    #1;
    total++; if (vec !== NONE_V) begin bad++; $display("FAIL reset_vec got=%b exp=%b", vec, NONE_V); end
    total++; if (a_halted !== 1'b0 || a_cause !== 2'b00) begin bad++; $display("FAIL reset_state halted=%b cause=%b exp 0/00", a_halted, a_cause); end
    total++; if (a_stalls !== 32'd0 || a_flushes !== 32'd0) begin bad++; $display("FAIL reset_perf got=%0d/%0d exp 0/0", a_stalls, a_flushes); end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_use();
    // lw x5 in EX, add x6,x5,x1 in ID
    idle(); id_valid = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd1; id_use_rs2 = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd5;
    #1;
    total++; if (vec !== LU_V) begin bad++; $display("FAIL lu_first got=%b exp=%b", vec, LU_V); end
    total++; if (vec3 !== LU_V) begin bad++; $display("FAIL lu3_first got=%b exp=%b", vec3, LU_V); end
    @(negedge clk);
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if (vec !== NONE_V) begin bad++; $display("FAIL lu_after c=%0d got=%b exp=%b", c, vec, NONE_V); end
      total++; if (vec3 !== LU_V) begin bad++; $display("FAIL lu3_hold c=%0d got=%b exp=%b", c, vec3, LU_V); end
      @(negedge clk);
    end
    #1;
    total++; if (vec3 !== NONE_V) begin bad++; $display("FAIL lu3_end got=%b exp=%b", vec3, NONE_V); end
    @(negedge clk);
    // hazard via rs2 only
    idle(); id_valid = 1'b1; id_rs1 = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd7;
    #1;
    total++; if (vec !== LU_V) begin bad++; $display("FAIL lu_rs2 got=%b exp=%b", vec, LU_V); end
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_no_hazard();
    idle(); id_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    #1;
    total++; if (vec !== NONE_V || vec3 !== NONE_V) begin bad++; $display("FAIL nohz_rd0 got=%b/%b exp=%b", vec, vec3, NONE_V); end
    @(negedge clk);
    ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0; id_rs2 = 5'd5; id_use_rs2 = 1'b0;
    #1;
    total++; if (vec !== NONE_V) begin bad++; $display("FAIL nohz_nouse got=%b exp=%b", vec, NONE_V); end
    @(negedge clk);
    ex_mem_read = 1'b0; id_use_rs1 = 1'b1;
    #1;
    total++; if (vec !== NONE_V) begin bad++; $display("FAIL nohz_noload got=%b exp=%b", vec, NONE_V); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_redirect_priority();
    idle(); id_valid = 1'b1; id_rs1 = 5'd9; id_use_rs1 = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9;
    ex_redirect = 1'b1;
    #1;
    total++; if (vec !== REDIR_V) begin bad++; $display("FAIL redir_vs_lu got=%b exp=%b", vec, REDIR_V); end
    mem_busy = 1'b1;
    #1;
    total++; if (vec !== BUSY_V) begin bad++; $display("FAIL busy_vs_redir got=%b exp=%b", vec, BUSY_V); end
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  task automatic test_trap();
    logic [1:0] expc;
    idle(); id_exception = 1'b1;
    #1;
    total++; if (vec !== NONE_V) begin bad++; $display("FAIL trap_novalid got=%b exp=%b", vec, NONE_V); end
    @(negedge clk);
    for (int v = 0; v < 3; v++) begin
      idle(); id_valid = 1'b1; id_exception = (v != 1); id_invalid = (v != 0);
      expc = (v == 1) ? 2'b10 : 2'b01;
      for (int d = 0; d <= DRAIN; d++) begin
        #1;
        total++; if (vec !== LU_V || a_halted !== 1'b0) begin bad++; $display("FAIL trap_drain v=%0d d=%0d got=%b h=%b exp=%b h=0", v, d, vec, a_halted, LU_V); end
        @(negedge clk);
      end
      #1;
      total++; if (a_halted !== 1'b1 || a_cause !== expc) begin bad++; $display("FAIL trap_halt v=%0d h=%b cause=%b exp 1/%b", v, a_halted, a_cause, expc); end
      mem_busy = 1'b1; ex_redirect = 1'b1;
      #1;
      total++; if (vec !== HALT_V) begin bad++; $display("FAIL halt_vec v=%0d got=%b exp=%b", v, vec, HALT_V); end
      @(negedge clk);
      mem_busy = 1'b0; ex_redirect = 1'b0; resume = 1'b1;
      #1;
      total++; if (vec !== RESUME_V) begin bad++; $display("FAIL resume_vec v=%0d got=%b exp=%b", v, vec, RESUME_V); end
      @(negedge clk);
      idle();
      #1;
      total++; if (a_halted !== 1'b0 || a_cause !== expc || vec !== NONE_V) begin bad++; $display("FAIL after_resume v=%0d h=%b cause=%b vec=%b exp 0/%b/%b", v, a_halted, a_cause, vec, expc, NONE_V); end
      @(negedge clk);
    end
  endtask

  task automatic test_trap_cancel();
    do_reset();
    id_valid = 1'b1; id_exception = 1'b1;
    #1;
    total++; if (vec !== LU_V) begin bad++; $display("FAIL cancel_trap got=%b exp=%b", vec, LU_V); end
    @(negedge clk);
    #1;
    total++; if (vec !== LU_V) begin bad++; $display("FAIL cancel_d1 got=%b exp=%b", vec, LU_V); end
    @(negedge clk);
    ex_redirect = 1'b1;
    #1;
    total++; if (vec !== REDIR_V) begin bad++; $display("FAIL cancel_redir got=%b exp=%b", vec, REDIR_V); end
    @(negedge clk);
    idle();
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (vec !== NONE_V || a_halted !== 1'b0 || a_cause !== 2'b00) begin bad++; $display("FAIL cancel_after c=%0d vec=%b h=%b cause=%b exp %b/0/00", c, vec, a_halted, a_cause, NONE_V); end
      @(negedge clk);
    end
  endtask

  task automatic test_drain_busy();
    int cycles;
    idle(); id_valid = 1'b1; id_exception = 1'b1;
    #1;
    total++; if (vec !== LU_V) begin bad++; $display("FAIL db_trap got=%b exp=%b", vec, LU_V); end
    @(negedge clk);
    cycles = 0;
    while (a_halted !== 1'b1 && cycles < 20) begin
      mem_busy = (cycles < 4);
      #1;
      if (cycles < 4) begin
        total++; if (vec !== BUSY_V) begin bad++; $display("FAIL db_busy c=%0d got=%b exp=%b", cycles, vec, BUSY_V); end
      end
      @(negedge clk);
      cycles++;
    end
    total++; if (cycles !== 7) begin bad++; $display("FAIL db_halt_latency got=%0d exp=7", cycles); end
    mem_busy = 1'b0; resume = 1'b1;
    @(negedge clk);
    idle(); id_valid = 1'b1; id_exception = 1'b1;
    @(negedge clk);
    idle();
    #1;
    rst_n = 1'b0; mem_busy = 1'b1;
    #1;
    total++; if (vec !== NONE_V || a_halted !== 1'b0 || a_cause !== 2'b00) begin bad++; $display("FAIL db_midreset vec=%b h=%b cause=%b exp %b/0/00", vec, a_halted, a_cause, NONE_V); end
    @(negedge clk);
    rst_n = 1'b1; mem_busy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (vec !== NONE_V || a_halted !== 1'b0) begin bad++; $display("FAIL db_residual c=%0d vec=%b h=%b exp %b/0", c, vec, a_halted, NONE_V); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int ld_left, drain_left;
    bit m_halt, hz, tp;
    logic [1:0] m_cause, m_pend;
    logic [6:0] exp;
    logic [31:0] m_stalls, m_flushes, e_stalls, e_flushes;
    do_reset();
    ld_left = 0; drain_left = 0; m_halt = 1'b0; m_cause = 2'b00; m_pend = 2'b00;
    m_stalls = 32'd0; m_flushes = 32'd0;
    for (int i = 0; i < 1500; i++) begin
      mem_busy     = ($urandom_range(0, 4) == 0);
      ex_redirect  = ($urandom_range(0, 9) == 0);
      ex_mem_read  = ($urandom_range(0, 1) == 1);
      ex_rd        = 5'($urandom_range(0, 3));
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_use_rs1   = ($urandom_range(0, 1) == 1);
      id_use_rs2   = ($urandom_range(0, 1) == 1);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_exception = ($urandom_range(0, 24) == 0);
      id_invalid   = ($urandom_range(0, 24) == 0);
      resume       = ($urandom_range(0, 3) == 0);
      hz = ex_mem_read && (ex_rd != 5'd0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      tp = id_valid && (id_exception || id_invalid);
`ifdef PIPE_CTRL_PERF_EN
      e_stalls = m_stalls; e_flushes = m_flushes;
`else
      e_stalls = 32'd0; e_flushes = 32'd0;
`endif
      #1;
      total++; if (a_halted !== m_halt || a_cause !== m_cause) begin bad++; $display("FAIL rand_state cyc=%0d h=%b cause=%b exp %b/%b", i, a_halted, a_cause, m_halt, m_cause); end
      total++; if (a_stalls !== e_stalls || a_flushes !== e_flushes) begin bad++; $display("FAIL rand_perf cyc=%0d got=%0d/%0d exp=%0d/%0d", i, a_stalls, a_flushes, e_stalls, e_flushes); end
      if (m_halt) begin
        exp = resume ? RESUME_V : HALT_V;
        if (resume) m_halt = 1'b0;
      end else if (mem_busy) begin
        exp = BUSY_V;
      end else if (ex_redirect) begin
        exp = REDIR_V; ld_left = 0; drain_left = 0; m_pend = 2'b00; m_flushes++;
      end else if (ld_left > 0) begin
        exp = LU_V; ld_left--;
      end else if (drain_left > 0) begin
        exp = LU_V; drain_left--;
        if (drain_left == 0) begin m_halt = 1'b1; m_cause = m_pend; end
      end else if (hz) begin
        exp = LU_V; ld_left = LDN - 1;
      end else if (tp) begin
        exp = LU_V; drain_left = DRAIN; m_pend = id_exception ? 2'b01 : 2'b10;
      end else begin
        exp = NONE_V;
      end
      if (exp[6] && !a_halted) m_stalls++;
      total++; if (vec !== exp) begin bad++; $display("FAIL rand_vec cyc=%0d got=%b exp=%b", i, vec, exp); end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_no_hazard();
    test_redirect_priority();
    test_trap();
    test_trap_cancel();
    test_drain_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
